// File: rtl/sweep_pkg.sv
// Shared state encoding and result-width helpers for the adder sweep controller.
package sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_e;

    // Up to 2^IN_W mismatches, so one bit beyond the vector width.
    function automatic int cnt_w(input int in_w);
        return in_w + 1;
    endfunction

    function automatic int sum_w(input int in_w, input int out_w);
        return out_w + in_w;
    endfunction

    function automatic int pop_w(input int out_w);
        return $clog2(out_w + 1);
    endfunction

    function automatic int hd_w(input int in_w, input int out_w);
        return pop_w(out_w) + in_w;
    endfunction

    // Counter holds SETTLE-1 at most; keep at least one bit.
    function automatic int settle_w(input int settle);
        return (settle < 2) ? 1 : $clog2(settle);
    endfunction

endpackage

// File: rtl/sweep_err_unit.sv
// Combinational comparison of the two partition outputs (|diff|, mismatch, and
// popcount of the xor when SWEEP_HD_EN is defined).
module sweep_err_unit
    import sweep_pkg::*;
#(
    parameter int OUT_W = 4
) (
    input  logic [OUT_W-1:0]        i_apx,
    input  logic [OUT_W-1:0]        i_ref,
    output logic [OUT_W-1:0]        o_abs_diff,
`ifdef SWEEP_HD_EN
    output logic [pop_w(OUT_W)-1:0] o_popcnt,
`endif
    output logic                    o_mismatch
);

    always_comb begin
        if (i_apx >= i_ref) o_abs_diff = i_apx - i_ref;
        else                o_abs_diff = i_ref - i_apx;
    end

    assign o_mismatch = (i_apx != i_ref);

`ifdef SWEEP_HD_EN
    localparam int PW = pop_w(OUT_W);
    logic [OUT_W-1:0] w_x;

    assign w_x = i_apx ^ i_ref;

    always_comb begin
        o_popcnt = '0;
        for (int i = 0; i < OUT_W; i++) begin
            o_popcnt = o_popcnt + PW'(w_x[i]);
        end
    end
`endif

endmodule

// File: rtl/adder_sweep_ctrl.sv
// Exhaustive input sweep comparing an approximate partition against its exact
// reference. Hamming-distance accumulation is built only when SWEEP_HD_EN is defined.
module adder_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int IN_W   = 7,
    parameter int OUT_W  = 4,
    parameter int SETTLE = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    output logic [IN_W-1:0]               pi,
    input  logic [OUT_W-1:0]              po_apx,
    input  logic [OUT_W-1:0]              po_ref,
    output logic                          busy,
    output logic                          done,
    output logic [cnt_w(IN_W)-1:0]        err_count,
    output logic [sum_w(IN_W, OUT_W)-1:0] err_sum,
    output logic [OUT_W-1:0]              err_max,
    output logic [hd_w(IN_W, OUT_W)-1:0]  hd_sum,
    output logic [1:0]                    dbg_state
);

    localparam int CW  = cnt_w(IN_W);
    localparam int SW  = sum_w(IN_W, OUT_W);
    localparam int STW = settle_w(SETTLE);
    localparam logic [STW-1:0] SETTLE_LOAD = STW'(SETTLE - 1);

    // Handshake: start is a request taken only in IDLE (busy=0, done=0); done is a
    // one-cycle completion pulse that needs no acknowledge. abort is honoured in APPLY/SAMPLE.
    sweep_state_e r_state;
    sweep_state_e w_next;

    logic [IN_W-1:0]  r_pi;
    logic [STW-1:0]   r_settle;
    logic [CW-1:0]    r_err_count;
    logic [SW-1:0]    r_err_sum;
    logic [OUT_W-1:0] r_err_max;

    logic [OUT_W-1:0] w_abs_diff;
    logic             w_mismatch;
    logic             w_accept;
    logic             w_abort;
    logic             w_sample;
    logic             w_last;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_abort  = abort && ((r_state == ST_APPLY) || (r_state == ST_SAMPLE));
    assign w_sample = (r_state == ST_SAMPLE) && !abort;
    assign w_last   = &r_pi;

`ifdef SWEEP_HD_EN
    localparam int HW = hd_w(IN_W, OUT_W);
    logic [pop_w(OUT_W)-1:0] w_popcnt;
    logic [HW-1:0]           r_hd_sum;
`endif

    sweep_err_unit #(
        .OUT_W (OUT_W)
    ) u_err (
        .i_apx      (po_apx),
        .i_ref      (po_ref),
        .o_abs_diff (w_abs_diff),
`ifdef SWEEP_HD_EN
        .o_popcnt   (w_popcnt),
`endif
        .o_mismatch (w_mismatch)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_APPLY;
            end
            ST_APPLY: begin
                if (abort)                w_next = ST_IDLE;
                else if (r_settle == '0)  w_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (abort)       w_next = ST_IDLE;
                else if (w_last) w_next = ST_DONE;
                else             w_next = ST_APPLY;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_APPLY, ST_SAMPLE: busy = 1'b1;
            ST_DONE:             done = 1'b1;
            default: ;
        endcase
    end

    // Abort wins over a same-cycle SAMPLE update, so partial results stay at the last sampled vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pi        <= '0;
            r_settle    <= '0;
            r_err_count <= '0;
            r_err_sum   <= '0;
            r_err_max   <= '0;
        end else if (w_accept) begin
            r_pi        <= '0;
            r_settle    <= SETTLE_LOAD;
            r_err_count <= '0;
            r_err_sum   <= '0;
            r_err_max   <= '0;
        end else if (w_abort) begin
            r_pi     <= '0;
            r_settle <= '0;
        end else if (r_state == ST_APPLY) begin
            if (r_settle != '0) r_settle <= r_settle - STW'(1);
        end else if (w_sample) begin
            r_err_count <= r_err_count + CW'(w_mismatch);
            r_err_sum   <= r_err_sum + SW'(w_abs_diff);
            if (w_abs_diff > r_err_max) r_err_max <= w_abs_diff;
            r_settle <= SETTLE_LOAD;
            r_pi     <= w_last ? '0 : r_pi + IN_W'(1);
        end
    end

`ifdef SWEEP_HD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_hd_sum <= '0;
        else if (w_accept) r_hd_sum <= '0;
        else if (w_sample) r_hd_sum <= r_hd_sum + HW'(w_popcnt);
    end

    assign hd_sum = r_hd_sum;
`else
    assign hd_sum = '0;
`endif

    assign pi        = r_pi;
    assign err_count = r_err_count;
    assign err_sum   = r_err_sum;
    assign err_max   = r_err_max;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_adder_sweep_ctrl.sv
// Scoreboard bench for adder_sweep_ctrl at IN_W=7, OUT_W=4, SETTLE=1 with directed partition models.
module tb_adder_sweep_ctrl;

    localparam int LAT = 256;
    localparam int EW  = 49;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [6:0]  pi;
    logic [3:0]  po_apx;
    logic [3:0]  po_ref;
    logic        busy;
    logic        done;
    logic [7:0]  err_count;
    logic [10:0] err_sum;
    logic [3:0]  err_max;
    logic [9:0]  hd_sum;
    logic [1:0]  dbg_state;

    int mode     = 0;
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    // {latency[15:0], err_count[7:0], err_sum[10:0], err_max[3:0], hd_sum[9:0]}
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    adder_sweep_ctrl #(
        .IN_W   (7),
        .OUT_W  (4),
        .SETTLE (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .pi        (pi),
        .po_apx    (po_apx),
        .po_ref    (po_ref),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .err_sum   (err_sum),
        .err_max   (err_max),
        .hd_sum    (hd_sum),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Partitions under test: 0 equal, 1 lsb flipped, 2 ref=pi[3:0] with apx=0.
    always_comb begin
        po_ref = pi[3:0] ^ {1'b0, pi[6:4]};
        po_apx = po_ref;
        case (mode)
            1: po_apx = po_ref ^ 4'b0001;
            2: begin
                po_ref = pi[3:0];
                po_apx = 4'h0;
            end
            default: ;
        endcase
    end

    function automatic int hdx(input int v);
`ifdef SWEEP_HD_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_results(input string name, input int c, input int s, input int m, input int h);
        check({name, "_err_count"}, 32'(err_count), c);
        check({name, "_err_sum"},   32'(err_sum),   s);
        check({name, "_err_max"},   32'(err_max),   m);
        check({name, "_hd_sum"},    32'(hd_sum),    hdx(h));
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_exp(input int c, input int s, input int m, input int h);
        exp_q.push_back({16'(LAT), 8'(c), 11'(s), 4'(m), 10'(hdx(h))});
    endtask

    task automatic issue_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        start   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < LAT + 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, 32'(seen), 1);
        @(negedge clk);
    endtask

    task automatic wait_pi_apply(input logic [6:0] v, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < LAT + 20 && !seen; i++) begin
            @(negedge clk);
            if (pi == v && dbg_state == 2'd1) seen = 1'b1;
        end
        check({name, "_reached_pi"}, 32'(seen), 1);
    endtask

    task automatic check_held(input string name, input int c, input int s, input int m, input int h);
        repeat (5) @(negedge clk);
        check({name, "_held_busy"}, 32'(busy), 0);
        check({name, "_held_pi"},   32'(pi),   0);
        check_results({name, "_held"}, c, s, m, h);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && done) begin
            check("done_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("latency",       32'(cyc - acc_cyc), 32'(mon_e[48:33]));
                check("sb_err_count",  32'(err_count),     32'(mon_e[32:25]));
                check("sb_err_sum",    32'(err_sum),       32'(mon_e[24:14]));
                check("sb_err_max",    32'(err_max),       32'(mon_e[13:10]));
                check("sb_hd_sum",     32'(hd_sum),        32'(mon_e[9:0]));
                check("done_pi",       32'(pi),            0);
                check("done_busy",     32'(busy),          0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mode  = 0;
        repeat (3) @(negedge clk);
        check("rst_pi",    32'(pi),        0);
        check("rst_busy",  32'(busy),      0);
        check("rst_done",  32'(done),      0);
        check("rst_state", 32'(dbg_state), 0);
        check_results("rst", 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);

        // Equal partitions: no errors.
        mode = 0;
        push_exp(0, 0, 0, 0);
        issue_start();
        @(negedge clk);
        check("eq_busy", 32'(busy), 1);
        wait_done("eq");
        check_held("eq", 0, 0, 0, 0);

        // LSB flipped on every vector.
        mode = 1;
        push_exp(128, 128, 1, 128);
        issue_start();
        wait_done("lsb");
        check_held("lsb", 128, 128, 1, 128);

        // ref=pi[3:0], apx=0: 120 mismatches, 8*(0..15) sums.
        mode = 2;
        push_exp(120, 960, 15, 256);
        issue_start();
        wait_done("low");
        check_held("low", 120, 960, 15, 256);

        // Abort in IDLE is ignored; results stay.
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_state", 32'(dbg_state), 0);
        check_results("idle_abort", 120, 960, 15, 256);

        // Abort at pi=10 in APPLY: vectors 0..9 only.
        mode = 2;
        issue_start();
        @(negedge clk);
        check_results("abort_cleared", 0, 0, 0, 0);
        wait_pi_apply(7'd10, "abort");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy",  32'(busy),      0);
        check("abort_pi",    32'(pi),        0);
        check("abort_state", 32'(dbg_state), 0);
        check_results("abort", 9, 45, 9, 15);
        check_held("abort", 9, 45, 9, 15);

        // start mid-sweep is ignored.
        mode = 0;
        push_exp(0, 0, 0, 0);
        issue_start();
        wait_pi_apply(7'd50, "midstart");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("midstart");

        // Reset mid-sweep clears everything at once and no done follows.
        mode = 1;
        issue_start();
        wait_pi_apply(7'd50, "midrst");
        rst = 1'b1;
        #1;
        check("midrst_pi",    32'(pi),        0);
        check("midrst_busy",  32'(busy),      0);
        check("midrst_done",  32'(done),      0);
        check("midrst_state", 32'(dbg_state), 0);
        check_results("midrst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 20) @(negedge clk);
        check("midrst_idle_state", 32'(dbg_state), 0);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_sweep_ctrl.md
ADDER_SWEEP_CTRL -- requirements
Module: adder_sweep_ctrl

Interface
REQ-001 SHALL have parameter IN_W, default 7, width of partition input vector.
REQ-002 SHALL have parameter OUT_W, default 4, width of partition output vector.
REQ-003 SHALL have parameter SETTLE, default 1, cycles (>=1) each vector is held before sampling.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have port start  in  1  sweep request, sampled in IDLE only.
REQ-007 SHALL have port abort  in  1  terminate sweep, return to IDLE without done.
REQ-008 SHALL have port pi  out  IN_W  stimulus vector to both partitions under test.
REQ-009 SHALL have port po_apx  in  OUT_W  approximate partition output.
REQ-010 SHALL have port po_ref  in  OUT_W  exact partition output.
REQ-011 SHALL have port busy  out  1  high in APPLY/SAMPLE.
REQ-012 SHALL have port done  out  1  one-cycle pulse on sweep completion.
REQ-013 SHALL have ports err_count  out  IN_W+1  mismatching vectors; err_sum  out  OUT_W+IN_W  sum of |po_apx-po_ref|; err_max  out  OUT_W  max |po_apx-po_ref|; hd_sum  out  $clog2(OUT_W+1)+IN_W  sum of Hamming distances.

Function
REQ-014 SHALL implement FSM IDLE, APPLY, SAMPLE, DONE.
REQ-015 IDLE with start=1 SHALL clear all accumulators, set pi=0, enter APPLY next cycle.
REQ-016 APPLY SHALL hold pi for exactly SETTLE cycles (down-counter), then enter SAMPLE.
REQ-017 SAMPLE SHALL, in one cycle, compare po_apx/po_ref (unsigned) and update: err_count+1 if unequal, err_sum+=|diff|, err_max=max(err_max,|diff|), hd_sum+=popcount(xor).
REQ-018 SAMPLE with pi != all-ones SHALL increment pi and return to APPLY; with pi == all-ones SHALL enter DONE (no wrap to 0 sweep repeat).
REQ-019 DONE SHALL assert done for one cycle, return to IDLE; pi SHALL return to 0.
REQ-020 Sweep SHALL take exactly 2^IN_W*(SETTLE+1) cycles from start acceptance to done pulse cycle exclusive of the IDLE->APPLY edge; defaults: 256 cycles.
REQ-021 Result outputs SHALL hold final values in IDLE until next accepted start.
REQ-022 start while busy or in DONE SHALL be ignored.
REQ-023 abort in APPLY/SAMPLE SHALL enter IDLE next cycle, no done pulse, partial results held, pi=0; abort has priority over SAMPLE update in same cycle; abort in IDLE ignored.
REQ-024 Accumulators SHALL be sized so no overflow is possible for any parameter set.

Reset
REQ-025 rst SHALL asynchronously force IDLE, pi=0, busy=0, done=0, all result outputs 0, settle counter 0.
REQ-026 rst mid-sweep SHALL discard the sweep; no done pulse follows reset release.

Configuration
REQ-027 Macro SWEEP_HD_EN defined: hd_sum accumulates per REQ-017.
REQ-028 SWEEP_HD_EN undefined: hd_sum SHALL be constant 0, no popcount logic or register synthesized; all else unchanged.

Structure
REQ-029 Package sweep_pkg SHALL hold FSM state enum and width helper constants (result widths as functions of IN_W/OUT_W).
REQ-030 One combinational sub-module sweep_err_unit SHALL compute |diff|, mismatch flag, popcount; instantiated once.

Verification (IN_W=7, OUT_W=4, SETTLE=1, SWEEP_HD_EN defined)
REQ-031 po_apx=po_ref for all pi -> done 256 cycles after start accept; err_count=0, err_sum=0, err_max=0, hd_sum=0.
REQ-032 po_apx=po_ref^4'b0001 -> err_count=128, err_sum=128, err_max=1, hd_sum=128.
REQ-033 po_ref=pi[3:0], po_apx=0 -> err_count=120, err_sum=960, err_max=15, hd_sum=256.
REQ-034 abort asserted while pi=10 in APPLY -> busy=0 next cycle, no done, pi=0, err_count reflects vectors 0-9 only.
REQ-035 start pulsed at pi=50 mid-sweep -> ignored, results identical to REQ-031 run; rst at pi=50 -> all outputs 0 immediately, no done.
REQ-036 Rebuild without SWEEP_HD_EN, rerun REQ-033 -> hd_sum=0, other results unchanged.
